// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller sharing one 2-to-4 select decoder among four requesters.
// The winner is registered as a one-hot grant plus its binary index, which drives the
// decoder select. Every release passes through IDLE, so ownership never changes without
// at least one dead cycle.
module rr_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 16,  // max consecutive grant cycles; 0 disables timeout
  parameter int unsigned CNT_W    = 4    // hold counter width, 2**CNT_W >= MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_sel,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // The counter value seen on the last permitted grant cycle. MAX_HOLD=0 makes this
  // all-ones, but it is never used in that case.
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam bit               TimeoutEn = (MAX_HOLD != 0);

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       hold_last;

  // Search ptr, ptr+1, ptr+2, ptr+3; scanning downwards lets the highest priority win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Forced release applies only when a timeout is configured.
  always_comb begin
    hold_last = TimeoutEn && (hold_cnt_q == HoldLast);
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt        <= '0;
      gnt_sel    <= '0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q    <= StGrant;
            gnt        <= 4'b0001 << win_idx;
            gnt_sel    <= win_idx;
            gnt_valid  <= 1'b1;
            ptr_q      <= win_idx + 2'd1;
            hold_cnt_q <= '0;
          end
        end
        StGrant: begin
          if (!req[gnt_sel]) begin
            state_q   <= StIdle;
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end else if (hold_last) begin
            state_q   <= StIdle;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
          end else if (hold_cnt_q != CntMax) begin
            // Saturate rather than wrap when no timeout is configured.
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  gnt_valid_a:  assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == |gnt);
  gnt_sel_a:    assert property (@(posedge clk) disable iff (!rst_n) gnt[gnt_sel] == gnt_valid);

endmodule
